// File: rtl/xor_stream_acc_if.sv
// Stream bundle for xor_stream_acc: word input and per-frame result output.
// out_parity exists only when XOR_STREAM_ACC_PARITY_EN is defined.
interface xor_stream_acc_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;
`ifdef XOR_STREAM_ACC_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_valid
`ifdef XOR_STREAM_ACC_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_valid
`ifdef XOR_STREAM_ACC_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/xor_stream_acc.sv
// Folds a framed word stream into a running XOR checksum and word count, one result per frame.
// Optional registered parity of the result is enabled by XOR_STREAM_ACC_PARITY_EN.
module xor_stream_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  xor_stream_acc_if.slave    bus,
  output logic               dbg_state_o
);
  // valid/ready: a transfer happens on a rising edge where valid & ready are both 1;
  // a source holds its payload until then, and ready never depends on the same side's valid.

  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             par_q, par_d;

  logic             in_ready;
  logic             in_fire;
  logic             last_fire;
  logic             out_fire;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_sat;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (last_fire) state_d = ST_HOLD;
      ST_HOLD: if (out_fire && !last_fire) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_ACC) | bus.out_ready;
    in_fire   = bus.in_valid & in_ready;
    last_fire = in_fire & bus.in_last;
    out_fire  = (state_q == ST_HOLD) & bus.out_ready;
    acc_next  = acc_q ^ bus.in_data;
    cnt_sat   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    count_d = count_q;
    par_d   = par_q;
    if (last_fire) begin
      data_d  = acc_next;
      count_d = cnt_sat;
      par_d   = ^acc_next;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (in_fire) begin
      acc_d = acc_next;
      cnt_d = cnt_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      par_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
      par_q   <= par_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_count = count_q;
  assign dbg_state_o   = state_q;

`ifdef XOR_STREAM_ACC_PARITY_EN
  assign bus.out_parity = par_q;
`else
  // Parity register is dropped by synthesis when the port is absent.
  logic unused_par;
  assign unused_par = par_q;
`endif
endmodule

// File: tb/tb_xor_stream_acc.sv
// Bench for xor_stream_acc: directed scenarios plus random traffic against a frame-level model.
// Two instances share stimulus: CNT_W=8 and CNT_W=2 (to exercise count saturation).
module tb_xor_stream_acc;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  xor_stream_acc_if #(.WIDTH(W), .CNT_W(8)) bus8 ();
  xor_stream_acc_if #(.WIDTH(W), .CNT_W(2)) bus2 ();
  logic dbg8, dbg2;

  xor_stream_acc #(.WIDTH(W), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .dbg_state_o(dbg8));
  xor_stream_acc #(.WIDTH(W), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state_o(dbg2));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // frame-level model: words of the open frame, and the currently presented result
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_data;
  int           m_n;
  logic         m_valid;
  bit           model_live = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  // compare then advance model, once per cycle, away from the active edge
  always @(negedge clk) begin
    logic         ordy, exp_rdy, acc, cons;
    logic [W-1:0] x;
    if (model_live) begin
      exp_rdy = !m_valid || bus8.out_ready;
      check("in_ready8", 32'(bus8.in_ready), 32'(exp_rdy));
      check("in_ready2", 32'(bus2.in_ready), 32'(exp_rdy));
      check("out_valid8", 32'(bus8.out_valid), 32'(m_valid));
      check("out_valid2", 32'(bus2.out_valid), 32'(m_valid));
      check("out_data8", 32'(bus8.out_data), 32'(m_data));
      check("out_data2", 32'(bus2.out_data), 32'(m_data));
      check("out_count8", 32'(bus8.out_count), 32'(sat(m_n, 255)));
      check("out_count2", 32'(bus2.out_count), 32'(sat(m_n, 3)));
`ifdef XOR_STREAM_ACC_PARITY_EN
      check("out_parity8", 32'(bus8.out_parity), 32'(^m_data));
      check("out_parity2", 32'(bus2.out_parity), 32'(^m_data));
`endif
    end
    if (rst) begin
      exp_q.delete();
      m_data = '0; m_n = 0; m_valid = 1'b0;
      model_live = 1;
    end else if (model_live) begin
      ordy = bus8.out_ready;
      acc  = bus8.in_valid && (!m_valid || ordy);
      cons = m_valid && ordy;
      if (acc) exp_q.push_back(bus8.in_data);
      if (acc && bus8.in_last) begin
        x = '0;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        m_data = x; m_n = exp_q.size(); m_valid = 1'b1;
        exp_q.delete();
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic l, input logic ordy);
    rst = r;
    bus8.in_valid = v; bus8.in_data = d; bus8.in_last = l; bus8.out_ready = ordy;
    bus2.in_valid = v; bus2.in_data = d; bus2.in_last = l; bus2.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [W-1:0] d, input logic l, input logic ordy);
    drive(1'b0, v, d, l, ordy);
    tick();
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] d, input int n8, input int n2);
    check({name, "_valid"}, 32'(bus8.out_valid), 32'd1);
    check({name, "_data8"}, 32'(bus8.out_data), 32'(d));
    check({name, "_data2"}, 32'(bus2.out_data), 32'(d));
    check({name, "_count8"}, 32'(bus8.out_count), 32'(n8));
    check({name, "_count2"}, 32'(bus2.out_count), 32'(n2));
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    tick(); tick();

    // reset values, idle
    beat(1'b0, '0, 1'b0, 1'b1);
    check("rst_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_data", 32'(bus8.out_data), 32'd0);
    check("rst_count", 32'(bus8.out_count), 32'd0);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
`ifdef XOR_STREAM_ACC_PARITY_EN
    check("rst_parity", 32'(bus8.out_parity), 32'd0);
`endif

    // reset mid-frame discards 0x11, 0x22
    beat(1'b1, 8'h11, 1'b0, 1'b1);
    beat(1'b1, 8'h22, 1'b0, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1); tick();
    beat(1'b1, 8'h0F, 1'b1, 1'b1);
    expect_result("midrst", 8'h0F, 1, 1);

    // four-word frame
    beat(1'b1, 8'h01, 1'b0, 1'b1);
    beat(1'b1, 8'h02, 1'b0, 1'b1);
    beat(1'b1, 8'h04, 1'b0, 1'b1);
    beat(1'b1, 8'h08, 1'b1, 1'b1);
    expect_result("four", 8'h0F, 4, 3);
    check("model_four_data", 32'(m_data), 32'h0F);
    check("model_four_n", 32'(m_n), 32'd4);
`ifdef XOR_STREAM_ACC_PARITY_EN
    check("four_parity", 32'(bus8.out_parity), 32'd0);
`endif
    beat(1'b0, '0, 1'b0, 1'b1);
    check("drain_valid", 32'(bus8.out_valid), 32'd0);

    // backpressure
    beat(1'b1, 8'hA5, 1'b1, 1'b0);
    expect_result("bp", 8'hA5, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
      #1;
      check("bp_in_ready", 32'(bus8.in_ready), 32'd0);
      tick();
      expect_result("bp_hold", 8'hA5, 1, 1);
    end
    drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
    #1;
    check("bp_release_ready", 32'(bus8.in_ready), 32'd1);
    tick();
    expect_result("bp_next", 8'hFF, 1, 1);

    // back-to-back single-word frames
    beat(1'b1, 8'h3C, 1'b1, 1'b1);
    expect_result("b2b0", 8'h3C, 1, 1);
    beat(1'b1, 8'hC3, 1'b1, 1'b1);
    expect_result("b2b1", 8'hC3, 1, 1);
    beat(1'b1, 8'h5A, 1'b1, 1'b1);
    expect_result("b2b2", 8'h5A, 1, 1);

    // count saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) beat(1'b1, 8'h01, (i == 4), 1'b1);
    expect_result("sat", 8'h01, 5, 3);

    // in_valid gaps
    beat(1'b1, 8'hF0, 1'b0, 1'b1);
    beat(1'b0, 8'h77, 1'b1, 1'b1);
    beat(1'b0, 8'h99, 1'b1, 1'b1);
    beat(1'b1, 8'h0F, 1'b1, 1'b1);
    expect_result("gap", 8'hFF, 2, 2);
`ifdef XOR_STREAM_ACC_PARITY_EN
    check("gap_parity", 32'(bus8.out_parity), 32'd0);
`endif

    // random traffic, checked every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            W'($urandom),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) != 0));
      tick();
    end

    beat(1'b0, '0, 1'b0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xor_stream_acc.md
# xor_stream_acc

Parametrised, clocked successor to the two-input XOR gate. It folds a stream of WIDTH-bit words into a running bitwise XOR checksum over frames delimited by a `last` flag. At each frame end it presents the checksum and the word count on a registered valid/ready output. It sits on data paths as a lightweight integrity check, for example before a link transmitter or after a buffer.

## Interface
Parameters:
- `WIDTH`, 8: data and checksum width in bits (≥1).
- `CNT_W`, 8: word-counter width in bits (≥1).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  input word.
- `in_valid`  in  1  input word is valid.
- `in_last`  in  1  input word is the final word of its frame; qualified by `in_valid`.
- `in_ready`  out  1  block can accept a word this cycle.
- `out_data`  out  WIDTH  XOR of all words in the completed frame.
- `out_count`  out  CNT_W  number of words in the frame, saturating.
- `out_valid`  out  1  result registers hold an unconsumed result.
- `out_ready`  in  1  downstream accepts the result.
- `out_parity`  out  1  XOR-reduction of `out_data`; present only with `XOR_STREAM_ACC_PARITY_EN`.

## Operation
- Handshakes:
  - Input beat accepted when `in_valid & in_ready`.
  - Output consumed when `out_valid & out_ready`.
- `in_ready = ~out_valid | out_ready`. This is combinational from `out_valid` and `out_ready` only, never from `in_valid`.
- Internal state:
  - `acc` (WIDTH bits).
  - `cnt` (CNT_W bits).
  - Result registers `out_data`, `out_count`, `out_valid` (and `out_parity`).
- Accepted beat with `in_last=0`:
  - `acc <= acc ^ in_data`.
  - `cnt <= sat(cnt+1)`.
- Accepted beat with `in_last=1`:
  - `out_data <= acc ^ in_data`.
  - `out_count <= sat(cnt+1)`.
  - `out_valid <= 1`.
  - `acc <= 0`, `cnt <= 0`.
- Saturation: `sat(x)` clamps to 2^CNT_W−1. `cnt` never wraps.
- Output consumed with no last beat accepted in the same cycle: `out_valid <= 0`. `out_data` and `out_count` hold their stale values.
- Same-cycle events: an output is consumed and a last beat is accepted. The new result loads and `out_valid` stays 1, giving one result per cycle at full rate.
- Result registers hold their values stable while `out_valid=1` and `out_ready=0`.
- While `out_valid=1` and `out_ready=0`, `in_ready=0`. No beats are accepted, so a complete result is never overwritten.
- Effective states:
  - ACC (`out_valid=0`): always ready.
  - HOLD (`out_valid=1`): ready only when `out_ready=1`.
- Transitions:
  - ACC→HOLD on an accepted last beat.
  - HOLD→ACC on consume without a new last beat.
  - HOLD→HOLD on consume plus a new last beat.
- `in_data` and `in_last` are ignored when `in_valid=0`.
- Single-word frame (`in_last=1` on the first beat): `out_data = in_data`, `out_count = 1`.

## Timing
- Reset values:
  - `acc=0`, `cnt=0`.
  - `out_data=0`, `out_count=0`, `out_valid=0`, `out_parity=0`.
  - `in_ready=1` in the cycle after the reset edge.
- Reset mid-frame or mid-HOLD discards the partial frame and any pending result. No output is produced for that frame.
- Latency: `out_valid` rises on the edge that accepts the last beat, so it is visible the following cycle.
- Throughput: one word per cycle while `out_ready=1`. No gap cycles between frames.
- No combinational path from `in_*` to `out_*`.

## Configuration
- `XOR_STREAM_ACC_PARITY_EN` defined:
  - `out_parity` port exists.
  - It is registered alongside `out_data` as `^(acc ^ in_data)`.
  - It resets to 0 and holds with the result.
- Macro not defined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then idle: all outputs at reset values, `in_ready=1`. Assert `rst` for 1 cycle mid-frame after words 0x11, 0x22; then send frame 0x0F(last) -> `out_data=0x0F`, `out_count=1`.
- WIDTH=8, frame 0x01, 0x02, 0x04, 0x08(last), `out_ready=1` -> one cycle after the last beat: `out_valid=1`, `out_data=0x0F`, `out_count=4`, `out_parity=0`.
- Backpressure: frame 0xA5(last) with `out_ready=0` for 3 cycles -> `out_valid=1`, `out_data=0xA5`, `out_parity=0`, `in_ready=0` stable for 3 cycles. `in_valid=1` with 0xFF(last) presented in those cycles is not accepted. Raise `out_ready` -> 0xFF frame accepted that cycle, next result 0xFF.
- Back-to-back single-word frames 0x3C, 0xC3, 0x5A with `out_ready=1` constant -> results 0x3C, 0xC3, 0x5A on consecutive cycles, `out_valid` continuously 1, `in_ready` continuously 1.
- CNT_W=2: 5-word frame of 0x01 each -> `out_data=0x01`, `out_count=3` (saturated).
- `in_valid` gaps: frame 0xF0, idle 2 cycles, 0x0F(last) -> `out_data=0xFF`, `out_count=2`, `out_parity=0`.
